// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage SIMD ALU with one shared opcode per beat.
// The block has LANES independent WIDTH-bit lanes, each with its own enable.
// It supports unsigned saturation for ADD and SUB, and keeps a sticky
// per-lane carry register. Valid/ready handshakes run on both the input
// and the output side.
module simd_alu_pipe #(
  parameter int LANES = 6,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   SrcAE,
  input  logic [LANES*WIDTH-1:0]   SrcBE,
  input  logic [2:0]               ALUControl,
  input  logic [LANES-1:0]         lane_en,
  input  logic                     sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*WIDTH-1:0]   vector,
  output logic [2*LANES-1:0]       ALUFlags,
  input  logic                     clr_sticky,
  output logic [LANES-1:0]         sticky_c
);

  localparam int SH = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MIN = 3'b111;

  logic                   r_s1_v;
  logic [LANES*WIDTH-1:0] r_a;
  logic [LANES*WIDTH-1:0] r_b;
  logic [2:0]             r_op;
  logic [LANES-1:0]       r_en;
  logic                   r_sat;

  logic                   r_s2_v;
  logic [LANES*WIDTH-1:0] r_vec;
  logic [2*LANES-1:0]     r_flags;
  logic [LANES-1:0]       r_sticky;

  logic                   w_s2_adv;
  logic                   w_deliver;
  logic [LANES*WIDTH-1:0] w_vec;
  logic [2*LANES-1:0]     w_flags;
  logic [LANES-1:0]       w_del_c;

  // S2 may take a new beat whenever it is empty or its beat is leaving.
  assign w_s2_adv  = !r_s2_v || out_ready;
  assign w_deliver = r_s2_v && out_ready;
  assign in_ready  = !r_s1_v || w_s2_adv;
  assign out_valid = r_s2_v;
  assign vector    = r_vec;
  assign ALUFlags  = r_flags;
  assign sticky_c  = r_sticky;

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_c;

    assign w_a   = r_a[g*WIDTH +: WIDTH];
    assign w_b   = r_b[g*WIDTH +: WIDTH];
    assign w_add = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub = {1'b0, w_a} - {1'b0, w_b};

    // Per-lane result and carry/borrow. Saturation clamps the result only;
    // C still reports the raw carry or borrow.
    always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      case (r_op)
        OP_ADD: begin
          w_c   = w_add[WIDTH];
          w_res = (r_sat && w_add[WIDTH]) ? '1 : w_add[WIDTH-1:0];
        end
        OP_SUB: begin
          w_c   = w_sub[WIDTH];
          w_res = (r_sat && w_sub[WIDTH]) ? '0 : w_sub[WIDTH-1:0];
        end
        OP_AND:  w_res = w_a & w_b;
        OP_OR:   w_res = w_a | w_b;
        OP_XOR:  w_res = w_a ^ w_b;
        OP_SHL:  w_res = w_a << w_b[SH-1:0];
        OP_SHR:  w_res = w_a >> w_b[SH-1:0];
        OP_MIN:  w_res = (w_a < w_b) ? w_a : w_b;
        default: w_res = '0;
      endcase
      if (!r_en[g]) begin
        w_res = '0;
        w_c   = 1'b0;
      end
    end

    assign w_vec[g*WIDTH +: WIDTH] = w_res;
    assign w_flags[2*g+1]          = r_en[g] && (w_res == '0);
    assign w_flags[2*g]            = w_c;
    // Disabled lanes already carry C=0, so no extra masking is needed here.
    assign w_del_c[g]              = r_flags[2*g];
  end

  // Stage 1: capture operands. Data registers update only on a real beat,
  // so they keep their last value through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_v <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= '0;
      r_en   <= '0;
      r_sat  <= 1'b0;
    end else if (in_ready) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_a   <= SrcAE;
        r_b   <= SrcBE;
        r_op  <= ALUControl;
        r_en  <= lane_en;
        r_sat <= sat;
      end
    end
  end

  // Stage 2: register the computed result and flags. While stalled, the
  // held values stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_v  <= 1'b0;
      r_vec   <= '0;
      r_flags <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_vec   <= w_vec;
        r_flags <= w_flags;
      end
    end
  end

  // Sticky carry: OR in the carries of each delivered beat. A clear takes
  // priority over a delivery in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= '0;
    end else if (clr_sticky) begin
      r_sticky <= '0;
    end else if (w_deliver) begin
      r_sticky <= r_sticky | w_del_c;
    end
  end

endmodule
